// File: rtl/iob_uart_mem_loader_pkg.sv
// Shared constants for the UART memory loader: 8N1 frame layout and the
// state encodings of the receiver and loader FSMs.
`timescale 1ns/1ps
package iob_uart_mem_loader_pkg;

  // 8N1 frame: one start bit, DATA_BITS data bits LSB first, one stop bit.
  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;

  // Receiver FSM encodings.
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Loader FSM encodings.
  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_LOAD = 2'd1;
  localparam logic [1:0] L_DONE = 2'd2;

endpackage

// File: rtl/iob_uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, start-bit glitch rejection and
// centre-of-bit sampling. Emits one-cycle byte-valid and frame-error pulses.
`timescale 1ns/1ps
module iob_uart_rx_core
  import iob_uart_mem_loader_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  input  logic                 rxd_i,
  output logic                 byte_valid_o,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 frame_err_o
);

  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_meta, rx_sync, rx_prev;
  logic [1:0]           state;
  logic [15:0]          baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // Resets to the idle-high line level so reset release never looks like a start.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else if (cke_i) begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value; blocking would collapse the chain into one flop.
      rx_meta <= rxd_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver FSM: start-bit check at half a bit, then data and stop bits at bit centres.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state        <= RX_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else if (cke_i) begin
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            // A line already back high at mid start bit was a glitch.
            state    <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_sync, shift[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rx_sync) byte_valid_o <= 1'b1;
            else         frame_err_o  <= 1'b1;
            state <= RX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign byte_o = shift;

endmodule

// File: rtl/iob_uart_mem_loader.sv
// Loads a block of 32-bit words received over an 8N1 UART into an external
// t2p_be RAM. Bytes are packed little-endian; the write-port outputs are
// registered here and wired straight to the RAM write port.
`timescale 1ns/1ps
module iob_uart_mem_loader
  import iob_uart_mem_loader_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W-1:0]   word_cnt_i,
  input  logic                rs232_rxd_i,
  output logic                rs232_rts_o,
  output logic [DATA_W-1:0]   ext_mem_w_data_o,
  output logic [DATA_W/8-1:0] ext_mem_w_strb_o,
  output logic [ADDR_W-1:0]   ext_mem_w_addr_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                frame_err_o
);

  logic                 rx_valid, rx_err;
  logic [DATA_BITS-1:0] rx_byte;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base, target, word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       byte_buf;

  iob_uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .cke_i        (cke_i),
    .rxd_i        (rs232_rxd_i),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (rx_err)
  );

  // Loader FSM: arms on start, packs bytes into words, issues one write per word.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      // NOTE: every register here is a flop, not a RAM, so all of it is reset; a reset mid-load aborts and drops the partial word.
      state            <= L_IDLE;
      base             <= '0;
      target           <= '0;
      word_idx         <= '0;
      byte_idx         <= '0;
      byte_buf         <= '0;
      ext_mem_w_data_o <= '0;
      ext_mem_w_strb_o <= '0;
      ext_mem_w_addr_o <= '0;
      frame_err_o      <= 1'b0;
    end else if (cke_i) begin
      ext_mem_w_strb_o <= '0;
      if (start_i && state != L_LOAD) begin
        // A byte completing in this same cycle is dropped in favour of the start.
        base        <= base_addr_i;
        target      <= word_cnt_i;
        word_idx    <= '0;
        byte_idx    <= '0;
        byte_buf    <= '0;
        frame_err_o <= 1'b0;
        state       <= (word_cnt_i == '0) ? L_DONE : L_LOAD;
      end else if (state == L_LOAD) begin
        if (ext_mem_w_strb_o != '0 && word_idx == target) begin
          // The last word is being written this cycle.
          state <= L_DONE;
        end else if (rx_valid) begin
          if (byte_idx == 2'd3) begin
            ext_mem_w_data_o <= {rx_byte, byte_buf};
            ext_mem_w_strb_o <= '1;
            ext_mem_w_addr_o <= base + word_idx;  // wraps modulo 2^ADDR_W
            word_idx         <= word_idx + 1'b1;
          end else begin
            byte_buf[byte_idx*8 +: 8] <= rx_byte;
          end
          byte_idx <= byte_idx + 2'd1;
        end
      end
      if (rx_err) frame_err_o <= 1'b1;
    end
  end

  assign busy_o      = (state == L_LOAD);
  assign done_o      = (state == L_DONE);
  assign rs232_rts_o = busy_o;

endmodule

// File: tb/tb_iob_uart_mem_loader.sv
// Self-checking bench for iob_uart_mem_loader: expected writes are queued as
// stimulus is planned and matched against every strobed write-port cycle.
`timescale 1ns/1ps
module tb_iob_uart_mem_loader;

  localparam int BAUD_DIV = 8;
  localparam int ADDR_W   = 16;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              cke = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_cnt = '0;
  logic              rxd = 1'b1;
  logic              rts;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [ADDR_W-1:0] w_addr;
  logic              busy, done, frame_err;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  write_cnt = 0;

  iob_uart_mem_loader #(
    .BAUD_DIV (BAUD_DIV),
    .ADDR_W   (ADDR_W),
    .DATA_W   (32)
  ) dut (
    .clk_i            (clk),
    .arst_n_i         (arst_n),
    .cke_i            (cke),
    .start_i          (start),
    .base_addr_i      (base_addr),
    .word_cnt_i       (word_cnt),
    .rs232_rxd_i      (rxd),
    .rs232_rts_o      (rts),
    .ext_mem_w_data_o (w_data),
    .ext_mem_w_strb_o (w_strb),
    .ext_mem_w_addr_o (w_addr),
    .busy_o           (busy),
    .done_o           (done),
    .frame_err_o      (frame_err)
  );

  // 1 MHz clock so a 3 us pulse is shorter than half a bit (4 cycles).
  always #500 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: each strobed cycle must match the oldest queued write.
  always @(negedge clk) begin
    if (arst_n && w_strb != 4'h0) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_strb", 64'(w_strb), 64'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(w_addr), 64'(e.addr));
        check("write_data", 64'(w_data), 64'(e.data));
        check("write_strb", 64'(w_strb), 64'hF);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BAUD_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
    @(negedge clk);
    base_addr = b;
    word_cnt  = c;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic glitch();
    @(negedge clk);
    rxd = 1'b0;
    #3000;
    rxd = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (write_cnt >= n) break;
      @(negedge clk);
    end
    check("write_count", 64'(write_cnt), 64'(n));
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_frame_err", 64'(frame_err), 64'h0);
    check("rst_rts", 64'(rts), 64'h0);
    check("rst_strb", 64'(w_strb), 64'h0);
    check("rst_addr", 64'(w_addr), 64'h0);
    check("rst_data", 64'(w_data), 64'h0);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic two-word load.
    pulse_start(16'h0010, 16'd2);
    check("t1_busy", 64'(busy), 64'h1);
    check("t1_rts", 64'(rts), 64'h1);
    check("t1_done", 64'(done), 64'h0);
    exp_q.push_back('{addr: 16'h0010, data: 32'h44332211});
    exp_q.push_back('{addr: 16'h0011, data: 32'hDDCCBBAA});
    send_word(32'h44332211);
    send_word(32'hDDCCBBAA);
    wait_writes(2);
    check("t1_done_end", 64'(done), 64'h1);
    check("t1_busy_end", 64'(busy), 64'h0);
    check("t1_rts_end", 64'(rts), 64'h0);
    check("t1_frame_err", 64'(frame_err), 64'h0);

    // Address wrap at the top of the address space.
    pulse_start(16'hFFFF, 16'd2);
    check("t2_done_cleared", 64'(done), 64'h0);
    exp_q.push_back('{addr: 16'hFFFF, data: 32'h04030201});
    exp_q.push_back('{addr: 16'h0000, data: 32'h08070605});
    send_word(32'h04030201);
    send_word(32'h08070605);
    wait_writes(4);
    check("t2_done_end", 64'(done), 64'h1);

    // Bad stop bit on the third byte: byte dropped, partial word kept.
    pulse_start(16'h0100, 16'd2);
    exp_q.push_back('{addr: 16'h0100, data: 32'h05040201});
    exp_q.push_back('{addr: 16'h0101, data: 32'h09080706});
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h33, 1'b0);
    check("t3_frame_err_set", 64'(frame_err), 64'h1);
    for (int i = 4; i <= 9; i++) send_byte(8'(i), 1'b1);
    wait_writes(6);
    check("t3_frame_err_sticky", 64'(frame_err), 64'h1);
    check("t3_done_end", 64'(done), 64'h1);

    // Zero-word load: done one cycle after start, no write.
    pulse_start(16'h0200, 16'd0);
    check("t4_done", 64'(done), 64'h1);
    check("t4_busy", 64'(busy), 64'h0);
    check("t4_frame_err_cleared", 64'(frame_err), 64'h0);
    repeat (20) @(negedge clk);
    check("t4_no_write", 64'(write_cnt), 64'd6);

    // Bytes outside a load and short glitches are ignored.
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    glitch();
    check("t5_no_write", 64'(write_cnt), 64'd6);
    pulse_start(16'h0300, 16'd1);
    glitch();
    exp_q.push_back('{addr: 16'h0300, data: 32'hDEADBEEF});
    send_word(32'hDEADBEEF);
    wait_writes(7);
    check("t5_done_end", 64'(done), 64'h1);

    // Reset mid-load aborts; the next load sees only new bytes.
    pulse_start(16'h0400, 16'd2);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_rts", 64'(rts), 64'h0);
    check("t6_rst_data", 64'(w_data), 64'h0);
    check("t6_rst_addr", 64'(w_addr), 64'h0);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_idle_after_rst", 64'(done), 64'h0);
    pulse_start(16'h0500, 16'd1);
    exp_q.push_back('{addr: 16'h0500, data: 32'h87654321});
    send_word(32'h87654321);
    wait_writes(8);
    check("t6_done_end", 64'(done), 64'h1);

    repeat (20) @(negedge clk);
    check("total_writes", 64'(write_cnt), 64'd8);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog in case the DUT wedges the stimulus.
  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iob_uart_mem_loader.md
IOB_UART_MEM_LOADER -- requirements
Module: iob_uart_mem_loader

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, clock cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter ADDR_W, default 16, external memory word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, memory word width; fixed at 32.
REQ-004 SHALL have port clk_i input 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port arst_n_i input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port cke_i input 1: clock enable; when low, all state holds.
REQ-007 SHALL have port start_i input 1: one-cycle pulse that arms a load.
REQ-008 SHALL have port base_addr_i input ADDR_W: first word address, sampled on an accepted start.
REQ-009 SHALL have port word_cnt_i input ADDR_W: number of words to load, sampled on an accepted start.
REQ-010 SHALL have port rs232_rxd_i input 1: serial data; 8N1 framing, LSB first, idle high.
REQ-011 SHALL have port rs232_rts_o output 1: high while the block accepts serial bytes.
REQ-012 SHALL have port ext_mem_w_data_o output 32: write data to the t2p_be RAM write port.
REQ-013 SHALL have port ext_mem_w_strb_o output 4: byte strobes; 4'hF on a write cycle, otherwise 0.
REQ-014 SHALL have port ext_mem_w_addr_o output ADDR_W: write word address.
REQ-015 SHALL have port busy_o output 1: high while a load is in progress.
REQ-016 SHALL have port done_o output 1: high once a load completes, until the next accepted start.
REQ-017 SHALL have port frame_err_o output 1: sticky; set on a bad stop bit, cleared by an accepted start.

Function
REQ-018 SHALL pass rs232_rxd_i through a 2-flop synchronizer (reset value 1) before any use.
REQ-019 SHALL implement the receiver FSM RX_IDLE->RX_START->RX_DATA->RX_STOP->RX_IDLE:
- falling edge in RX_IDLE enters RX_START;
- line re-sampled at BAUD_DIV/2; if high, return to RX_IDLE (glitch);
- 8 data bits sampled every BAUD_DIV cycles at bit centre;
- stop bit sampled one BAUD_DIV later.
REQ-020 SHALL accept a byte only when the stop bit samples 1; a stop bit of 0 discards the byte and sets frame_err_o.
REQ-021 SHALL run the loader FSM L_IDLE->L_LOAD->L_DONE; start_i is accepted in L_IDLE or L_DONE and ignored in L_LOAD.
REQ-022 SHALL pack accepted bytes little-endian: 1st byte into [7:0], 4th into [31:24].
REQ-023 SHALL, one cycle after the 4th byte's stop sample, assert strb=4'hF for exactly one cycle with addr = base + word index.
REQ-024 SHALL compute addresses modulo 2^ADDR_W, so base+index wraps silently.
REQ-025 SHALL enter L_DONE in the cycle after the write of word word_cnt_i-1; busy_o falls and done_o rises in that same cycle.
REQ-026 SHALL, for word_cnt_i==0, go L_IDLE->L_DONE the cycle after start with no write issued.
REQ-027 SHALL discard bytes received while not in L_LOAD; rs232_rts_o equals busy_o.
REQ-028 SHALL NOT advance the byte counter on a discarded byte; a partial word in progress is kept.
REQ-029 SHALL, when start_i and a byte completion coincide in L_DONE, accept the start and discard the byte.

Reset
REQ-030 SHALL, on arst_n_i low, immediately force: both FSMs idle, counters 0, strb 0, data 0, addr 0, busy_o/done_o/frame_err_o 0, rs232_rts_o 0.
REQ-031 SHALL treat reset mid-load as an abort: no further writes, partial word lost, restart only via start_i.

Structure
REQ-032 SHALL put FSM state encodings and the 8N1 frame constants (DATA_BITS=8) in shared package iob_uart_mem_loader_pkg.
REQ-033 SHALL contain one sub-module, iob_uart_rx_core (synchronizer plus RX FSM), which outputs a byte-valid pulse, the byte, and a frame-error pulse.
REQ-034 SHALL connect its ext_mem_w_* outputs directly to the write port of iob_ram_t2p_be with no extra register stage.

Verification
REQ-035 With BAUD_DIV=8, base=0x0010, cnt=2, bytes 0x11,0x22,0x33,0x44,0xAA,0xBB,0xCC,0xDD -> writes 0x44332211@0x0010 and 0xDDCCBBAA@0x0011, then done_o=1.
REQ-036 base=0xFFFF, cnt=2, 8 bytes -> writes at 0xFFFF then 0x0000.
REQ-037 cnt=2; byte 3 sent with stop=0, then 6 valid bytes -> frame_err_o=1, first word is bytes 1,2,4,5, exactly two writes.
REQ-038 cnt=0 -> done_o=1 one cycle after start, strb never nonzero.
REQ-039 3 µs low pulse on rxd (shorter than BAUD_DIV/2) and bytes sent before start -> no byte accepted, no write.
REQ-040 arst_n_i low after 2 bytes, then start with cnt=1 and 4 new bytes -> a single write containing only the new bytes.
